// File: rtl/ahb_slave_port_arbiter_pkg.sv
// Shared types, payload field layout and burst helpers for the AHB slave-port arbiter.
package ahb_slave_port_arbiter_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_t;

   localparam int DEF_MASTER_NUM = 2;
   localparam int DEF_PAY_LOAD   = 78;

   localparam int HADDR_LSB     = 46;
   localparam int HADDR_W       = 32;
   localparam int HWDATA_LSB    = 14;
   localparam int HWDATA_W      = 32;
   localparam int HTRANS_LSB    = 12;
   localparam int HSIZE_LSB     = 9;
   localparam int HBURST_LSB    = 6;
   localparam int HPROT_LSB     = 2;
   localparam int HWRITE_BIT    = 1;
   localparam int HMASTLOCK_BIT = 0;

   // Fixed-length bursts report their beat count; SINGLE and undefined INCR report 1.
   function automatic logic [4:0] burst_beats(hburst_t burst);
      case (burst)
         HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
         default:                      burst_beats = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_if.sv
// Request/response bundle between the masters, the arbiter and the slave on one slave port.
interface ahb_slave_port_arbiter_if
   import ahb_slave_port_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = DEF_MASTER_NUM,
   parameter int PAY_LOAD   = DEF_PAY_LOAD
);
   logic [MASTER_NUM-1:0][PAY_LOAD-1:0] payload_in;
   logic [MASTER_NUM-1:0]               hreq;
   logic                                hready_slave;
   logic [PAY_LOAD-1:0]                 payload_out;
   logic [MASTER_NUM-1:0]               hgrant;
   logic [MASTER_NUM-1:0]               data_sel;
   logic [MASTER_NUM-1:0]               hready_mst;

   modport master (
      output payload_in, hreq, hready_slave,
      input  payload_out, hgrant, data_sel, hready_mst
   );

   modport slave (
      input  payload_in, hreq, hready_slave,
      output payload_out, hgrant, data_sel, hready_mst
   );
endinterface

// File: rtl/ahb_slave_port_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester after rr_ptr wins, rr_ptr itself last.
module ahb_rr_picker #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     grant
);
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = PTR_W'((int'(rr_ptr) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// Request-side stage of an AHB slave port: round-robin grant held across locks and fixed bursts,
// address fields from the address-phase owner, HWDATA from the data-phase owner.
module ahb_slave_port_arbiter
   import ahb_slave_port_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = DEF_MASTER_NUM,
   parameter int PAY_LOAD   = DEF_PAY_LOAD
) (
   input logic               HCLK,
   input logic               HRESET,
   ahb_slave_port_arbiter_if.slave bus
);
   localparam int PTR_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

   logic [MASTER_NUM-1:0] hgrant_q, hgrant_d, data_sel_q, data_sel_d, pick;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [3:0]            beat_cnt_q, beat_cnt_d;
   logic                  locked_q, locked_d;

   logic [PAY_LOAD-1:0]   own_pay, pay_out;
   logic [HWDATA_W-1:0]   dat_wdata;
   logic                  own_req, has_owner, own_lock, releasable;
   htrans_t               own_trans;
   hburst_t               own_burst;

   always_comb begin
      own_pay   = '0;
      dat_wdata = '0;
      own_req   = 1'b0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (hgrant_q[i]) begin
            own_pay = own_pay | bus.payload_in[i];
            own_req = own_req | bus.hreq[i];
         end
         if (data_sel_q[i])
            dat_wdata = dat_wdata | bus.payload_in[i][HWDATA_LSB +: HWDATA_W];
      end
      pay_out = own_pay;
      pay_out[HWDATA_LSB +: HWDATA_W] = dat_wdata;
   end

   assign has_owner = |hgrant_q;
   assign own_trans = htrans_t'(own_pay[HTRANS_LSB +: 2]);
   assign own_burst = hburst_t'(own_pay[HBURST_LSB +: 3]);
   assign own_lock  = own_pay[HMASTLOCK_BIT];

   // A registered lock pins the owner even through IDLE or a dropped request.
   assign releasable = !has_owner ||
                       (!locked_q && (!own_req ||
                        (!own_lock && ((own_trans == HTRANS_IDLE) ||
                                       (own_trans == HTRANS_NONSEQ && own_burst == HBURST_SINGLE) ||
                                       (own_trans == HTRANS_SEQ && beat_cnt_q == 4'd1)))));

   ahb_rr_picker #(.N(MASTER_NUM), .PTR_W(PTR_W)) u_picker (
      .req    (bus.hreq),
      .rr_ptr (rr_ptr_q),
      .grant  (pick)
   );

   always_comb begin
      hgrant_d   = hgrant_q;
      data_sel_d = data_sel_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      locked_d   = locked_q;
      if (bus.hready_slave) begin
         data_sel_d = (has_owner && (own_trans == HTRANS_NONSEQ || own_trans == HTRANS_SEQ))
                      ? hgrant_q : '0;
         if (has_owner && own_req) begin
            if (own_trans == HTRANS_NONSEQ)
               beat_cnt_d = 4'(burst_beats(own_burst) - 5'd1);
            else if (own_trans == HTRANS_SEQ && beat_cnt_q != 4'd0)
               beat_cnt_d = beat_cnt_q - 4'd1;
            locked_d = own_lock;
         end
         if (releasable) begin
            hgrant_d = pick;
            locked_d = 1'b0;
            for (int i = 0; i < MASTER_NUM; i++)
               if (pick[i]) rr_ptr_d = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         hgrant_q   <= '0;
         data_sel_q <= '0;
         rr_ptr_q   <= PTR_W'(MASTER_NUM - 1);
         beat_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         hgrant_q   <= hgrant_d;
         data_sel_q <= data_sel_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         locked_q   <= locked_d;
      end
   end

   // Masters not yet granted are stalled; reset releases everyone.
   always_comb begin
      bus.hready_mst = '1;
      for (int i = 0; i < MASTER_NUM; i++)
         bus.hready_mst[i] = HRESET |
                             ((hgrant_q[i] | data_sel_q[i]) ? bus.hready_slave : ~bus.hreq[i]);
   end

   assign bus.payload_out = pay_out;
   assign bus.hgrant      = hgrant_q;
   assign bus.data_sel    = data_sel_q;
endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed bench for the AHB slave-port arbiter: reset, alternation, bursts, stalls, locks, mid-burst reset.
module tb_ahb_slave_port_arbiter;
   import ahb_slave_port_arbiter_pkg::*;

   logic HCLK;
   logic HRESET;
   int   pass_cnt;
   int   total_cnt;

   ahb_slave_port_arbiter_if #(.MASTER_NUM(2), .PAY_LOAD(78)) bus ();

   ahb_slave_port_arbiter #(.MASTER_NUM(2), .PAY_LOAD(78)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   function automatic logic [77:0] mk(htrans_t t, hburst_t b, logic lock,
                                      logic [31:0] addr, logic [31:0] wdata);
      logic [77:0] p;
      p        = '0;
      p[77:46] = addr;
      p[45:14] = wdata;
      p[13:12] = t;
      p[11:9]  = 3'd2;
      p[8:6]   = b;
      p[5:2]   = 4'h3;
      p[1]     = 1'b1;
      p[0]     = lock;
      return p;
   endfunction

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic apply_reset();
      HRESET = 1'b1;
      bus.hreq = 2'b00;
      bus.payload_in[0] = '0;
      bus.payload_in[1] = '0;
      bus.hready_slave = 1'b1;
      repeat (2) @(posedge HCLK);
      #1;
      HRESET = 1'b0;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      bus.hready_slave = 1'b1;
      bus.hreq = 2'b11;
      bus.payload_in[0] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h1000_0000, 32'hAAAA_0000);
      bus.payload_in[1] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h2000_0000, 32'hBBBB_0000);
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b00) $display("FAIL reset_hgrant got=%b exp=00", bus.hgrant);
      else pass_cnt++;
      total_cnt++;
      if (bus.data_sel !== 2'b00) $display("FAIL reset_data_sel got=%b exp=00", bus.data_sel);
      else pass_cnt++;
      total_cnt++;
      if (bus.payload_out !== 78'd0) $display("FAIL reset_payload got=%h exp=0", bus.payload_out);
      else pass_cnt++;
      total_cnt++;
      if (bus.hready_mst !== 2'b11) $display("FAIL reset_hready_mst got=%b exp=11", bus.hready_mst);
      else pass_cnt++;
      HRESET = 1'b0;
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b01) $display("FAIL first_grant got=%b exp=01", bus.hgrant);
      else pass_cnt++;
      total_cnt++;
      if (bus.data_sel !== 2'b00) $display("FAIL first_data_sel got=%b exp=00", bus.data_sel);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.data_sel !== 2'b01) $display("FAIL second_data_sel got=%b exp=01", bus.data_sel);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g [4];
      logic [1:0] exp_r [4];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_r = '{2'b01, 2'b11, 2'b11, 2'b11};
      apply_reset();
      bus.hreq = 2'b11;
      bus.payload_in[0] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h1000_0004, 32'hD000_0000);
      bus.payload_in[1] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h2000_0008, 32'hD111_1111);
      for (int c = 0; c < 4; c++) begin
         tick();
         total_cnt++;
         if (bus.hgrant !== exp_g[c]) $display("FAIL b2b_hgrant[%0d] got=%b exp=%b", c, bus.hgrant, exp_g[c]);
         else pass_cnt++;
         total_cnt++;
         if (bus.hready_mst !== exp_r[c]) $display("FAIL b2b_hready_mst[%0d] got=%b exp=%b", c, bus.hready_mst, exp_r[c]);
         else pass_cnt++;
         if (c == 1) begin
            total_cnt++;
            if (bus.payload_out !== mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h2000_0008, 32'hD000_0000))
               $display("FAIL b2b_payload_m1_addr got=%h", bus.payload_out);
            else pass_cnt++;
         end
         if (c == 2) begin
            total_cnt++;
            if (bus.payload_out !== mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h1000_0004, 32'hD111_1111))
               $display("FAIL b2b_payload_m0_addr got=%h", bus.payload_out);
            else pass_cnt++;
         end
      end
      bus.hready_slave = 1'b0;
      #1;
      total_cnt++;
      if (bus.hready_mst !== 2'b00) $display("FAIL stall_hready_mst got=%b exp=00", bus.hready_mst);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b10) $display("FAIL stall_hold_hgrant got=%b exp=10", bus.hgrant);
      else pass_cnt++;
      bus.hready_slave = 1'b1;
   endtask

   task automatic run_incr4(input int stall_cycles);
      apply_reset();
      bus.hreq = 2'b11;
      bus.payload_in[1] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h2000_0000, 32'h0);
      bus.payload_in[0] = mk(HTRANS_NONSEQ, HBURST_INCR4, 1'b0, 32'h1000_0000, 32'h0);
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b01) $display("FAIL incr4_s%0d_grant0 got=%b exp=01", stall_cycles, bus.hgrant);
      else pass_cnt++;
      for (int beat = 1; beat <= 3; beat++) begin
         tick();
         total_cnt++;
         if (bus.hgrant !== 2'b01) $display("FAIL incr4_s%0d_hold_beat%0d got=%b exp=01", stall_cycles, beat, bus.hgrant);
         else pass_cnt++;
         bus.payload_in[0] = mk(HTRANS_SEQ, HBURST_INCR4, 1'b0, 32'h1000_0000 + 32'(4 * beat), 32'h0);
         if (beat == 2 && stall_cycles > 0) begin
            bus.hready_slave = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               tick();
               total_cnt++;
               if (bus.hgrant !== 2'b01 || bus.data_sel !== 2'b01)
                  $display("FAIL incr4_stall%0d got=%b/%b exp=01/01", s, bus.hgrant, bus.data_sel);
               else pass_cnt++;
            end
            bus.hready_slave = 1'b1;
         end
      end
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b10) $display("FAIL incr4_s%0d_switch got=%b exp=10", stall_cycles, bus.hgrant);
      else pass_cnt++;
      total_cnt++;
      if (bus.data_sel !== 2'b01) $display("FAIL incr4_s%0d_last_dsel got=%b exp=01", stall_cycles, bus.data_sel);
      else pass_cnt++;
   endtask

   task automatic test_incr4();
      run_incr4(0);
   endtask

   task automatic test_incr4_stall();
      run_incr4(2);
   endtask

   task automatic test_lock();
      logic [77:0] m1_seq [4];
      logic [1:0]  exp_g  [4];
      m1_seq[0] = mk(HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 32'h2000_0000, 32'h0);
      m1_seq[1] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 32'h2000_0004, 32'h0);
      m1_seq[2] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h2000_0008, 32'h0);
      m1_seq[3] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h2000_000C, 32'h0);
      exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
      apply_reset();
      bus.hreq = 2'b10;
      bus.payload_in[0] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h1000_0000, 32'h0);
      bus.payload_in[1] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 32'h2000_0000, 32'h0);
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b10) $display("FAIL lock_first_grant got=%b exp=10", bus.hgrant);
      else pass_cnt++;
      total_cnt++;
      if (bus.hready_mst !== 2'b11) $display("FAIL lock_idle_m0_ready got=%b exp=11", bus.hready_mst);
      else pass_cnt++;
      bus.hreq = 2'b11;
      for (int c = 0; c < 4; c++) begin
         tick();
         total_cnt++;
         if (bus.hgrant !== exp_g[c]) $display("FAIL lock_hold[%0d] got=%b exp=%b", c, bus.hgrant, exp_g[c]);
         else pass_cnt++;
         bus.payload_in[1] = m1_seq[c];
      end
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b01) $display("FAIL lock_release got=%b exp=01", bus.hgrant);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      bus.hreq = 2'b11;
      bus.payload_in[1] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h2000_0000, 32'h0);
      bus.payload_in[0] = mk(HTRANS_NONSEQ, HBURST_INCR8, 1'b0, 32'h1000_0000, 32'h0);
      tick();
      tick();
      bus.payload_in[0] = mk(HTRANS_SEQ, HBURST_INCR8, 1'b0, 32'h1000_0004, 32'h0);
      tick();
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b01 || bus.data_sel !== 2'b01)
         $display("FAIL mid_incr8_owner got=%b/%b exp=01/01", bus.hgrant, bus.data_sel);
      else pass_cnt++;
      #2;
      HRESET = 1'b1;
      #1;
      total_cnt++;
      if (bus.hgrant !== 2'b00 || bus.data_sel !== 2'b00)
         $display("FAIL async_reset_clear got=%b/%b exp=00/00", bus.hgrant, bus.data_sel);
      else pass_cnt++;
      total_cnt++;
      if (bus.payload_out[13:12] !== 2'b00) $display("FAIL async_reset_htrans got=%b exp=00", bus.payload_out[13:12]);
      else pass_cnt++;
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      bus.payload_in[0] = mk(HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 32'h1000_0000, 32'h0);
      tick();
      total_cnt++;
      if (bus.hgrant !== 2'b01) $display("FAIL restart_grant got=%b exp=01", bus.hgrant);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      HRESET = 1'b1;
      bus.hreq = 2'b00;
      bus.hready_slave = 1'b1;
      bus.payload_in[0] = '0;
      bus.payload_in[1] = '0;
      test_reset();
      test_back_to_back();
      test_incr4();
      test_incr4_stall();
      test_lock();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
